tod_clock_core: RTL and testbench
=================================

// Module: tod_clock_core
// PURPOSE
// Parametrised, single-clock time-of-day core: BCD HH:MM counter with 12/24-hour display,
// NUM_ALARMS loadable alarms with arm/ack/snooze, and validated digit load. Runs on system
// clk with a 1-cycle tick_in strobe from the divider; no derived or muxed clocks. Feeds the
// display mux and buzzer logic.
// PARAMETERS
// TICKS_PER_MIN  60  tick_in pulses per minute increment (>=1)
// NUM_ALARMS     2   number of alarm registers (1..7)
// SNOOZE_MIN     5   minutes from snooze until re-ring (>=1)
// PORTS
// clk            in   1         system clock, all state on posedge
// rst_24hr_cond  in   1         reset, asynchronous, active-high
// en             in   1         run enable for timebase
// tick_in        in   1         1-cycle timebase strobe
// mode_12h       in   1         1: disp_bcd in 12-hour format, 0: 24-hour
// load_en        in   1         load mode; freezes timebase while high
// load_stb       in   1         1-cycle write strobe (only honoured when load_en=1)
// load_tgt       in   3         0 = clock, k = alarm k-1
// load_sel       in   2         digit: 0 min0, 1 min1, 2 hr0, 3 hr1
// load_val       in   4         BCD digit to write
// alarm_arm      in   NUM_ALARMS per-alarm arm level
// snooze         in   1         1-cycle snooze request
// alarm_ack      in   1         1-cycle acknowledge, clears all rings and snoozes
// time_bcd       out  16        {hr1,hr0,min1,min0}, always 24-hour
// disp_bcd       out  16        mode-adjusted time, combinational from time_bcd/mode_12h
// pm             out  1         1 when hours >= 12 (both modes)
// min_tick       out  1         1-cycle pulse on each timebase minute increment
// alarm_ring     out  NUM_ALARMS per-alarm ring level
// alarm_bcd      out  16*NUM_ALARMS  alarm k at bits [16k+15:16k]
// load_err       out  1         1-cycle pulse on rejected write
// BEHAVIOUR
// - Reset: time 00:00, all alarms 00:00, sec counter 0, ring 0, snooze idle, min_tick 0, load_err 0.
// - Sec counter 0..TICKS_PER_MIN-1 advances on tick_in & en & !load_en. On tick at terminal
//   count: counter->0, minute increments, min_tick=1 next cycle. Other inputs never move it.
// - Minute increment is BCD: min0 9->0 carries min1; min1 5->0 carries hours; 23:59->00:00 in
//   one cycle. No illegal intermediate values are ever visible.
// - Load: load_stb & load_en writes load_val into the selected digit next cycle. Legal iff
//   min0<=9, min1<=5, hr0<=9, hr1<=2, and resulting hours<=23 (hr1=2 with hr0>3 is illegal
//   either way). Illegal digit or load_tgt>NUM_ALARMS: no write, load_err=1 for one cycle.
//   A clock write also zeroes the sec counter. load_stb with load_en=0 is ignored, no error.
// - Alarm match is evaluated only on a minute increment: if alarm k is armed and the new time
//   equals alarm k, alarm_ring[k] is set in the same cycle time_bcd updates. Loads that make
//   time equal to an alarm never trigger a ring.
// - Ring holds until alarm_ack, or until alarm_arm[k]=0, which clears ring[k] and snooze[k].
// - snooze while any ring set: clear those rings; each loads its snooze counter = SNOOZE_MIN.
//   The counter decrements on min_tick; when it reaches 0, ring[k] is set again (if still armed).
//   snooze with no ring active: ignored.
// - Same cycle alarm_ack+snooze: ack wins, and all snooze counters go idle. Ack in the same
//   cycle as a new match: the match wins and the ring is set.
// - 12h display: hr 00 -> 12 (pm=0), 01-11 unchanged, 12 -> 12 (pm=1), 13-23 -> 01-11 (pm=1).
//   Minutes are unchanged.
// - Async reset mid-load or mid-ring returns to reset state immediately; no pulse outputs follow.
// TESTING
// - TICKS_PER_MIN=2: time 23:59, two ticks -> time_bcd 16'h0000, min_tick one cycle,
//   sec counter 0.
// - Load hr1=2 while hr0=5 -> load_err pulse, time unchanged; hr0=3 then hr1=2 -> 23:xx.
// - Alarm0=07:30 armed, time 07:29, minute increment -> alarm_ring[0]=1 with time_bcd 16'h0730.
// - Ringing, snooze -> ring 0; after SNOOZE_MIN min_ticks -> ring 1; ack+snooze same cycle
//   -> ring 0, no re-ring.
// - mode_12h=1: time 00:05 -> disp 16'h1205 pm 0; 13:45 -> 16'h0145 pm 1; 12:00 -> 16'h1200 pm 1.
// - load_en held with tick_in pulsing -> time frozen; rst_24hr_cond mid-ring -> all outputs
//   reset value.

Source files
------------

// File: rtl/tod_clock_core.sv
// tod_clock_core: BCD HH:MM time-of-day counter on a single system clock.
// A 1-cycle tick_in strobe advances a seconds prescaler; each full minute
// bumps the BCD time, evaluates the alarm registers and emits min_tick.
// Digits are loaded one at a time with legality checking, and each alarm
// has its own ring flag and snooze countdown driven by min_tick.
module tod_clock_core #(
  parameter int TICKS_PER_MIN = 60,
  parameter int NUM_ALARMS    = 2,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic                    clk,
  input  logic                    rst_24hr_cond,
  input  logic                    en,
  input  logic                    tick_in,
  input  logic                    mode_12h,
  input  logic                    load_en,
  input  logic                    load_stb,
  input  logic [2:0]              load_tgt,
  input  logic [1:0]              load_sel,
  input  logic [3:0]              load_val,
  input  logic [NUM_ALARMS-1:0]   alarm_arm,
  input  logic                    snooze,
  input  logic                    alarm_ack,
  output logic [15:0]             time_bcd,
  output logic [15:0]             disp_bcd,
  output logic                    pm,
  output logic                    min_tick,
  output logic [NUM_ALARMS-1:0]   alarm_ring,
  output logic [16*NUM_ALARMS-1:0] alarm_bcd,
  output logic                    load_err
);

  // Prescaler must hold at least one bit even when a single tick is a minute.
  localparam int SEC_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int SNZ_W = $clog2(SNOOZE_MIN + 1);

  // Time is kept packed as {hr1, hr0, min1, min0}, always 24-hour.
  logic [15:0]      time_q, time_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             min_tick_q, min_tick_d;
  logic             load_err_q, load_err_d;
  logic [15:0]      alarm_q [NUM_ALARMS];
  logic [15:0]      alarm_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] ring_q, ring_d;
  logic [NUM_ALARMS-1:0] snz_act_q, snz_act_d;
  logic [SNZ_W-1:0] snz_cnt_q [NUM_ALARMS];
  logic [SNZ_W-1:0] snz_cnt_d [NUM_ALARMS];

  // Combinational helpers shared by the next-state blocks.
  logic        adv;
  logic        sec_term;
  logic        min_inc;
  logic [15:0] time_next;
  logic        load_wr;
  logic        tgt_ok;
  logic        digits_ok;
  logic        load_ok;
  logic        clk_wr;
  logic [15:0] load_base;
  logic [15:0] load_cand;
  logic        any_ring;

  // One-minute BCD increment; all carries resolve in a single step so
  // 23:59 goes straight to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] m0, m1, h0, h1;
    {h1, h0, m1, m0} = t;
    if (m0 != 4'd9) begin
      m0 = m0 + 4'd1;
    end else begin
      m0 = 4'd0;
      if (m1 != 4'd5) begin
        m1 = m1 + 4'd1;
      end else begin
        m1 = 4'd0;
        if (h1 == 4'd2 && h0 == 4'd3) begin
          h1 = 4'd0;
          h0 = 4'd0;
        end else if (h0 == 4'd9) begin
          h0 = 4'd0;
          h1 = h1 + 4'd1;
        end else begin
          h0 = h0 + 4'd1;
        end
      end
    end
    return {h1, h0, m1, m0};
  endfunction

  // Timebase qualification: loading freezes the prescaler.
  always_comb begin
    adv       = tick_in & en & ~load_en;
    sec_term  = (sec_q == SEC_W'(TICKS_PER_MIN - 1));
    min_inc   = adv & sec_term;
    time_next = bcd_inc(time_q);
  end

  // Load decode: build the candidate register value with one digit replaced
  // and accept it only if the whole HH:MM stays a legal 24-hour time.
  always_comb begin
    load_wr   = load_stb & load_en;
    tgt_ok    = ({29'd0, load_tgt} <= 32'(NUM_ALARMS));
    load_base = time_q;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if ({29'd0, load_tgt} == 32'(k + 1)) load_base = alarm_q[k];
    end
    load_cand = load_base;
    case (load_sel)
      2'd0:    load_cand[3:0]   = load_val;
      2'd1:    load_cand[7:4]   = load_val;
      2'd2:    load_cand[11:8]  = load_val;
      default: load_cand[15:12] = load_val;
    endcase
    digits_ok = (load_cand[3:0] <= 4'd9) && (load_cand[7:4] <= 4'd5) &&
                (load_cand[11:8] <= 4'd9) && (load_cand[15:12] <= 4'd2) &&
                !(load_cand[15:12] == 4'd2 && load_cand[11:8] > 4'd3);
    load_ok    = load_wr & tgt_ok & digits_ok;
    load_err_d = load_wr & ~(tgt_ok & digits_ok);
    clk_wr     = load_ok & (load_tgt == 3'd0);
  end

  // Time, prescaler and alarm register next state.
  always_comb begin
    time_d     = time_q;
    sec_d      = sec_q;
    min_tick_d = min_inc;
    if (clk_wr) begin
      time_d = load_cand;
      sec_d  = '0;
    end else if (adv) begin
      sec_d = sec_term ? '0 : sec_q + SEC_W'(1);
      if (min_inc) time_d = time_next;
    end
    for (int k = 0; k < NUM_ALARMS; k++) begin
      alarm_d[k] = alarm_q[k];
      if (load_ok && ({29'd0, load_tgt} == 32'(k + 1))) alarm_d[k] = load_cand;
    end
  end

  // Ring/snooze next state. Later statements take priority: snooze expiry,
  // then ack (beats snooze), then disarm, then a fresh match on the minute
  // increment, which beats a simultaneous ack.
  always_comb begin
    any_ring = |ring_q;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      ring_d[k]    = ring_q[k];
      snz_act_d[k] = snz_act_q[k];
      snz_cnt_d[k] = snz_cnt_q[k];
      if (min_tick_q && snz_act_q[k]) begin
        if (snz_cnt_q[k] == SNZ_W'(1)) begin
          snz_act_d[k] = 1'b0;
          snz_cnt_d[k] = '0;
          if (alarm_arm[k]) ring_d[k] = 1'b1;
        end else begin
          snz_cnt_d[k] = snz_cnt_q[k] - SNZ_W'(1);
        end
      end
      if (alarm_ack) begin
        ring_d[k]    = 1'b0;
        snz_act_d[k] = 1'b0;
        snz_cnt_d[k] = '0;
      end else if (snooze && any_ring && ring_q[k]) begin
        ring_d[k]    = 1'b0;
        snz_act_d[k] = 1'b1;
        snz_cnt_d[k] = SNZ_W'(SNOOZE_MIN);
      end
      if (!alarm_arm[k]) begin
        ring_d[k]    = 1'b0;
        snz_act_d[k] = 1'b0;
        snz_cnt_d[k] = '0;
      end
      if (min_inc && alarm_arm[k] && (time_next == alarm_q[k])) ring_d[k] = 1'b1;
    end
  end

  // State registers with asynchronous reset back to 00:00 and idle alarms.
  always_ff @(posedge clk or posedge rst_24hr_cond) begin
    if (rst_24hr_cond) begin
      time_q     <= '0;
      sec_q      <= '0;
      min_tick_q <= 1'b0;
      load_err_q <= 1'b0;
      ring_q     <= '0;
      snz_act_q  <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        alarm_q[k]   <= '0;
        snz_cnt_q[k] <= '0;
      end
    end else begin
      time_q     <= time_d;
      sec_q      <= sec_d;
      min_tick_q <= min_tick_d;
      load_err_q <= load_err_d;
      ring_q     <= ring_d;
      snz_act_q  <= snz_act_d;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        alarm_q[k]   <= alarm_d[k];
        snz_cnt_q[k] <= snz_cnt_d[k];
      end
    end
  end

  // 12-hour view: 00 shows as 12, 13..23 fold down to 01..11.
  // BCD folding: 13-19 -> 01-07, 20-21 -> 08-09, 22-23 -> 10-11.
  always_comb begin
    logic [3:0] hr1;
    logic [3:0] hr0;
    logic [7:0] disp_hr;
    hr1     = time_q[15:12];
    hr0     = time_q[11:8];
    disp_hr = {hr1, hr0};
    pm      = (hr1 == 4'd2) || (hr1 == 4'd1 && hr0 >= 4'd2);
    if (mode_12h) begin
      if (hr1 == 4'd0 && hr0 == 4'd0) begin
        disp_hr = 8'h12;
      end else if (hr1 == 4'd1 && hr0 >= 4'd3) begin
        disp_hr = {4'd0, hr0 - 4'd2};
      end else if (hr1 == 4'd2 && hr0 <= 4'd1) begin
        disp_hr = {4'd0, hr0 + 4'd8};
      end else if (hr1 == 4'd2) begin
        disp_hr = {4'd1, hr0 - 4'd2};
      end
    end
    disp_bcd = {disp_hr, time_q[7:0]};
  end

  assign time_bcd   = time_q;
  assign min_tick   = min_tick_q;
  assign load_err   = load_err_q;
  assign alarm_ring = ring_q;

  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm_out
    assign alarm_bcd[16*gi +: 16] = alarm_q[gi];
  end

endmodule

// File: tb/tb_tod_clock_core.sv
// Directed bench for tod_clock_core with a 2-tick minute and 3-minute snooze.
module tb_tod_clock_core;

  localparam int TPM = 2;
  localparam int NA  = 2;
  localparam int SM  = 3;

  logic          clk;
  logic          rst_24hr_cond;
  logic          en;
  logic          tick_in;
  logic          mode_12h;
  logic          load_en;
  logic          load_stb;
  logic [2:0]    load_tgt;
  logic [1:0]    load_sel;
  logic [3:0]    load_val;
  logic [NA-1:0] alarm_arm;
  logic          snooze;
  logic          alarm_ack;
  logic [15:0]   time_bcd;
  logic [15:0]   disp_bcd;
  logic          pm;
  logic          min_tick;
  logic [NA-1:0] alarm_ring;
  logic [16*NA-1:0] alarm_bcd;
  logic          load_err;

  int vectors;
  int miscompares;

  tod_clock_core #(
    .TICKS_PER_MIN(TPM),
    .NUM_ALARMS(NA),
    .SNOOZE_MIN(SM)
  ) dut (
    .clk(clk),
    .rst_24hr_cond(rst_24hr_cond),
    .en(en),
    .tick_in(tick_in),
    .mode_12h(mode_12h),
    .load_en(load_en),
    .load_stb(load_stb),
    .load_tgt(load_tgt),
    .load_sel(load_sel),
    .load_val(load_val),
    .alarm_arm(alarm_arm),
    .snooze(snooze),
    .alarm_ack(alarm_ack),
    .time_bcd(time_bcd),
    .disp_bcd(disp_bcd),
    .pm(pm),
    .min_tick(min_tick),
    .alarm_ring(alarm_ring),
    .alarm_bcd(alarm_bcd),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  task automatic tick_min();
    repeat (TPM) do_tick();
  endtask

  task automatic load_digit(input logic [2:0] t, input logic [1:0] s, input logic [3:0] v,
                            output logic err);
    load_en  = 1'b1;
    load_tgt = t;
    load_sel = s;
    load_val = v;
    load_stb = 1'b1;
    step();
    err      = load_err;
    load_stb = 1'b0;
  endtask

  // Writes HH:MM in an order that never forms an illegal intermediate hour.
  task automatic load_hhmm(input logic [2:0] t, input logic [15:0] v);
    logic e;
    load_digit(t, 2'd3, 4'd0, e);
    load_digit(t, 2'd2, v[11:8], e);
    load_digit(t, 2'd3, v[15:12], e);
    load_digit(t, 2'd1, v[7:4], e);
    load_digit(t, 2'd0, v[3:0], e);
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_24hr_cond = 1'b1;
    en = 1'b1; tick_in = 1'b0; mode_12h = 1'b0; load_en = 1'b0; load_stb = 1'b0;
    load_tgt = '0; load_sel = '0; load_val = '0; alarm_arm = '0; snooze = 1'b0; alarm_ack = 1'b0;
    repeat (3) step();
    vectors++; if (time_bcd !== 16'h0000) begin miscompares++; $display("FAIL reset_time got %h want 0000", time_bcd); end
    vectors++; if (disp_bcd !== 16'h0000) begin miscompares++; $display("FAIL reset_disp got %h want 0000", disp_bcd); end
    vectors++; if (pm !== 1'b0) begin miscompares++; $display("FAIL reset_pm got %b want 0", pm); end
    vectors++; if (min_tick !== 1'b0) begin miscompares++; $display("FAIL reset_min_tick got %b want 0", min_tick); end
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL reset_ring got %b want 00", alarm_ring); end
    vectors++; if (alarm_bcd !== 32'h0) begin miscompares++; $display("FAIL reset_alarm_bcd got %h want 0", alarm_bcd); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL reset_load_err got %b want 0", load_err); end
    #2 rst_24hr_cond = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_rollover();
    load_hhmm(3'd0, 16'h2359);
    do_tick();
    vectors++; if (time_bcd !== 16'h2359) begin miscompares++; $display("FAIL roll_first_tick got %h want 2359", time_bcd); end
    vectors++; if (min_tick !== 1'b0) begin miscompares++; $display("FAIL roll_first_mt got %b want 0", min_tick); end
    do_tick();
    vectors++; if (time_bcd !== 16'h0000) begin miscompares++; $display("FAIL roll_wrap got %h want 0000", time_bcd); end
    vectors++; if (min_tick !== 1'b1) begin miscompares++; $display("FAIL roll_mt got %b want 1", min_tick); end
    step();
    vectors++; if (min_tick !== 1'b0) begin miscompares++; $display("FAIL roll_mt_width got %b want 0", min_tick); end
    do_tick();
    vectors++; if (time_bcd !== 16'h0000) begin miscompares++; $display("FAIL roll_sec_zero got %h want 0000", time_bcd); end
    do_tick();
    vectors++; if (time_bcd !== 16'h0001) begin miscompares++; $display("FAIL roll_next_min got %h want 0001", time_bcd); end
    load_hhmm(3'd0, 16'h1959);
    tick_min();
    vectors++; if (time_bcd !== 16'h2000) begin miscompares++; $display("FAIL roll_hr_carry got %h want 2000", time_bcd); end
    $display("test_rollover done");
  endtask

  task automatic test_load_err();
    logic e;
    load_hhmm(3'd0, 16'h1500);
    load_digit(3'd0, 2'd3, 4'd2, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL err_hr25 got %b want 1", e); end
    vectors++; if (time_bcd !== 16'h1500) begin miscompares++; $display("FAIL err_hr25_time got %h want 1500", time_bcd); end
    step();
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL err_pulse_width got %b want 0", load_err); end
    load_digit(3'd0, 2'd2, 4'd3, e);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL err_hr0_3 got %b want 0", e); end
    load_digit(3'd0, 2'd3, 4'd2, e);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL err_hr1_2 got %b want 0", e); end
    vectors++; if (time_bcd !== 16'h2300) begin miscompares++; $display("FAIL err_time_23 got %h want 2300", time_bcd); end
    load_digit(3'd0, 2'd1, 4'd6, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL err_min1_6 got %b want 1", e); end
    vectors++; if (time_bcd !== 16'h2300) begin miscompares++; $display("FAIL err_min1_time got %h want 2300", time_bcd); end
    load_digit(3'd3, 2'd0, 4'd1, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL err_bad_tgt got %b want 1", e); end
    vectors++; if (alarm_bcd !== 32'h0) begin miscompares++; $display("FAIL err_bad_tgt_alarm got %h want 0", alarm_bcd); end
    load_en = 1'b0; load_tgt = 3'd0; load_sel = 2'd0; load_val = 4'd7; load_stb = 1'b1;
    step();
    load_stb = 1'b0;
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL ign_stb_err got %b want 0", load_err); end
    vectors++; if (time_bcd !== 16'h2300) begin miscompares++; $display("FAIL ign_stb_time got %h want 2300", time_bcd); end
    $display("test_load_err done");
  endtask

  task automatic test_alarm();
    load_hhmm(3'd1, 16'h0730);
    vectors++; if (alarm_bcd !== 32'h0000_0730) begin miscompares++; $display("FAIL alarm_load got %h want 00000730", alarm_bcd); end
    alarm_arm = 2'b01;
    load_hhmm(3'd0, 16'h0730);
    step();
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL load_no_ring got %b want 00", alarm_ring); end
    load_hhmm(3'd0, 16'h0729);
    do_tick();
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL pre_match got %b want 00", alarm_ring); end
    tick_in = 1'b1; alarm_ack = 1'b1;
    step();
    tick_in = 1'b0; alarm_ack = 1'b0;
    vectors++; if (time_bcd !== 16'h0730) begin miscompares++; $display("FAIL match_time got %h want 0730", time_bcd); end
    vectors++; if (alarm_ring !== 2'b01) begin miscompares++; $display("FAIL match_ring_vs_ack got %b want 01", alarm_ring); end
    vectors++; if (min_tick !== 1'b1) begin miscompares++; $display("FAIL match_mt got %b want 1", min_tick); end
    $display("test_alarm done");
  endtask

  task automatic test_snooze();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL snooze_clear got %b want 00", alarm_ring); end
    tick_min();
    tick_min();
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL snooze_early got %b want 00", alarm_ring); end
    tick_min();
    step();
    vectors++; if (alarm_ring !== 2'b01) begin miscompares++; $display("FAIL snooze_rering got %b want 01", alarm_ring); end
    alarm_ack = 1'b1; snooze = 1'b1;
    step();
    alarm_ack = 1'b0; snooze = 1'b0;
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL ack_snooze got %b want 00", alarm_ring); end
    repeat (SM + 1) tick_min();
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL ack_snooze_idle got %b want 00", alarm_ring); end
    vectors++; if (time_bcd !== 16'h0737) begin miscompares++; $display("FAIL snooze_time got %h want 0737", time_bcd); end
    // Ack while a snooze countdown is running must cancel it.
    load_hhmm(3'd0, 16'h0729);
    tick_min();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    repeat (SM + 1) tick_min();
    step();
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL ack_cancel_snooze got %b want 00", alarm_ring); end
    // Disarming clears a ringing alarm.
    load_hhmm(3'd0, 16'h0729);
    tick_min();
    vectors++; if (alarm_ring !== 2'b01) begin miscompares++; $display("FAIL rearm_match got %b want 01", alarm_ring); end
    alarm_arm = 2'b00;
    step();
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL disarm_clear got %b want 00", alarm_ring); end
    $display("test_snooze done");
  endtask

  task automatic test_12h();
    mode_12h = 1'b1;
    load_hhmm(3'd0, 16'h0005);
    vectors++; if (disp_bcd !== 16'h1205) begin miscompares++; $display("FAIL h12_0005 got %h want 1205", disp_bcd); end
    vectors++; if (pm !== 1'b0) begin miscompares++; $display("FAIL h12_0005_pm got %b want 0", pm); end
    load_hhmm(3'd0, 16'h1345);
    vectors++; if (disp_bcd !== 16'h0145) begin miscompares++; $display("FAIL h12_1345 got %h want 0145", disp_bcd); end
    vectors++; if (pm !== 1'b1) begin miscompares++; $display("FAIL h12_1345_pm got %b want 1", pm); end
    load_hhmm(3'd0, 16'h1200);
    vectors++; if (disp_bcd !== 16'h1200) begin miscompares++; $display("FAIL h12_1200 got %h want 1200", disp_bcd); end
    vectors++; if (pm !== 1'b1) begin miscompares++; $display("FAIL h12_1200_pm got %b want 1", pm); end
    load_hhmm(3'd0, 16'h2159);
    vectors++; if (disp_bcd !== 16'h0959) begin miscompares++; $display("FAIL h12_2159 got %h want 0959", disp_bcd); end
    load_hhmm(3'd0, 16'h2359);
    vectors++; if (disp_bcd !== 16'h1159) begin miscompares++; $display("FAIL h12_2359 got %h want 1159", disp_bcd); end
    vectors++; if (time_bcd !== 16'h2359) begin miscompares++; $display("FAIL h12_time24 got %h want 2359", time_bcd); end
    load_hhmm(3'd0, 16'h1100);
    vectors++; if (disp_bcd !== 16'h1100 || pm !== 1'b0) begin miscompares++; $display("FAIL h12_1100 got %h/%b want 1100/0", disp_bcd, pm); end
    mode_12h = 1'b0;
    load_hhmm(3'd0, 16'h1345);
    vectors++; if (disp_bcd !== 16'h1345) begin miscompares++; $display("FAIL h24_1345 got %h want 1345", disp_bcd); end
    $display("test_12h done");
  endtask

  task automatic test_freeze();
    load_hhmm(3'd0, 16'h1010);
    load_en = 1'b1;
    repeat (3) begin
      do_tick();
      vectors++; if (min_tick !== 1'b0) begin miscompares++; $display("FAIL freeze_mt got %b want 0", min_tick); end
    end
    vectors++; if (time_bcd !== 16'h1010) begin miscompares++; $display("FAIL freeze_time got %h want 1010", time_bcd); end
    load_en = 1'b0;
    do_tick();
    vectors++; if (time_bcd !== 16'h1010) begin miscompares++; $display("FAIL freeze_sec_held got %h want 1010", time_bcd); end
    do_tick();
    vectors++; if (time_bcd !== 16'h1011) begin miscompares++; $display("FAIL freeze_resume got %h want 1011", time_bcd); end
    en = 1'b0;
    tick_min();
    vectors++; if (time_bcd !== 16'h1011) begin miscompares++; $display("FAIL en_low got %h want 1011", time_bcd); end
    en = 1'b1;
    $display("test_freeze done");
  endtask

  task automatic test_reset_mid_ring();
    alarm_arm = 2'b01;
    load_hhmm(3'd0, 16'h0729);
    tick_min();
    vectors++; if (alarm_ring !== 2'b01) begin miscompares++; $display("FAIL pre_rst_ring got %b want 01", alarm_ring); end
    load_en = 1'b1; load_tgt = 3'd0; load_sel = 2'd3; load_val = 4'd9; load_stb = 1'b1;
    #3 rst_24hr_cond = 1'b1;
    #1;
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL rst_ring got %b want 00", alarm_ring); end
    vectors++; if (time_bcd !== 16'h0000) begin miscompares++; $display("FAIL rst_time got %h want 0000", time_bcd); end
    vectors++; if (alarm_bcd !== 32'h0) begin miscompares++; $display("FAIL rst_alarm got %h want 0", alarm_bcd); end
    vectors++; if (min_tick !== 1'b0) begin miscompares++; $display("FAIL rst_mt got %b want 0", min_tick); end
    load_stb = 1'b0; load_en = 1'b0;
    step();
    #2 rst_24hr_cond = 1'b0;
    step();
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL rst_no_err got %b want 0", load_err); end
    vectors++; if (min_tick !== 1'b0) begin miscompares++; $display("FAIL rst_no_mt got %b want 0", min_tick); end
    vectors++; if (alarm_ring !== 2'b00) begin miscompares++; $display("FAIL rst_after_ring got %b want 00", alarm_ring); end
    $display("test_reset_mid_ring done");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_rollover();
    test_load_err();
    test_alarm();
    test_snooze();
    test_12h();
    test_freeze();
    test_reset_mid_ring();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
